// File: rtl/sop_seq_pkg.sv
// Shared types for the time-multiplexed sum-of-products engine:
// operand transform modes, FSM states and the mode field width.
package sop_seq_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        PASS = 3'd0,
        NEG  = 3'd1,
        XOR  = 3'd2,
        SGNB = 3'd3,
        INV  = 3'd4,
        SHR  = 3'd5,
        SHL  = 3'd6,
        ZERO = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sop_operand_xform.sv
// Combinational W-bit operand transform selected at runtime by a 3-bit mode.
module sop_operand_xform
    import sop_seq_pkg::*;
#(
    parameter int            W   = 8,
    parameter int            SH  = 3,
    parameter logic [W-1:0]  KEY = 8'h69
) (
    input  logic [W-1:0]      v,
    input  logic [MODE_W-1:0] mode,
    output logic [W-1:0]      res
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    always_comb begin
        res = '0;
        case (mode_e'(mode))
            PASS:    res = v;
            NEG:     res = W'(0) - v;
            XOR:     res = v ^ KEY;
            // Sign-smear both halves: top from the MSB, bottom from the lower half's MSB
            SGNB:    res = {{HI{v[W-1]}}, {LO{v[LO-1]}}};
            INV:     res = ~v;
            SHR:     res = v >> SH;
            SHL:     res = v << SH;
            ZERO:    res = '0;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/sop_seq_engine.sv
// Sequential sum-of-products engine: one shared truncating multiplier walks the
// captured terms, then scales the accumulator by the negated, key-masked scale.
module sop_seq_engine
    import sop_seq_pkg::*;
#(
    parameter int             W      = 8,
    parameter int             SW     = 4,
    parameter int             NTERMS = 3,
    parameter int             OW     = 16,
    parameter int             SH     = 3,
    parameter logic [W-1:0]   KEY    = 8'h69,
    parameter logic [SW-1:0]  SKEY   = 4'h6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NTERMS*W-1:0]        op_x,
    input  logic [NTERMS*W-1:0]        op_y,
    input  logic [NTERMS*MODE_W-1:0]   mode_x,
    input  logic [NTERMS*MODE_W-1:0]   mode_y,
    input  logic [SW-1:0]              s,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OW-1:0]              g
);

    localparam int IDXW = (NTERMS > 1) ? $clog2(NTERMS) : 1;

    state_e                     state_reg, state_next;
    logic [NTERMS*W-1:0]        x_reg, y_reg;
    logic [NTERMS*MODE_W-1:0]   mx_reg, my_reg;
    logic [SW-1:0]              s_reg;
    logic [OW-1:0]              acc_reg;
    logic [IDXW-1:0]            idx_reg;

    logic [W-1:0]               x_term [NTERMS];
    logic [W-1:0]               y_term [NTERMS];
    logic [MODE_W-1:0]          mx_term [NTERMS];
    logic [MODE_W-1:0]          my_term [NTERMS];
    logic [W-1:0]               x_xf, y_xf;
    logic [SW-1:0]              s_neg;
    logic [OW-1:0]              mul_a, mul_b, prod;
    logic                       last_term;
    logic                       accept;

    genvar gi;
    generate
        for (gi = 0; gi < NTERMS; gi++) begin : g_unpack
            assign x_term[gi]  = x_reg[gi*W +: W];
            assign y_term[gi]  = y_reg[gi*W +: W];
            assign mx_term[gi] = mx_reg[gi*MODE_W +: MODE_W];
            assign my_term[gi] = my_reg[gi*MODE_W +: MODE_W];
        end
    endgenerate

    sop_operand_xform #(.W(W), .SH(SH), .KEY(KEY)) u_xform_x (
        .v    (x_term[idx_reg]),
        .mode (mx_term[idx_reg]),
        .res  (x_xf)
    );

    sop_operand_xform #(.W(W), .SH(SH), .KEY(KEY)) u_xform_y (
        .v    (y_term[idx_reg]),
        .mode (my_term[idx_reg]),
        .res  (y_xf)
    );

    assign s_neg     = SW'(0) - (s_reg ^ SKEY);
    assign last_term = (idx_reg == IDXW'(NTERMS - 1));
    assign accept    = in_valid && in_ready && !clear;

    // The single multiplier is steered to the term pair in MAC and to acc*s' in SCALE
    always_comb begin
        mul_a = OW'(x_xf);
        mul_b = OW'(y_xf);
        if (state_reg == SCALE) begin
            mul_a = acc_reg;
            mul_b = OW'(s_neg);
        end
    end

    assign prod = mul_a * mul_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (in_valid) state_next = MAC;
                MAC:     if (last_term) state_next = SCALE;
                SCALE:   state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            mx_reg  <= '0;
            my_reg  <= '0;
            s_reg   <= '0;
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
            idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg   <= op_x;
                        y_reg   <= op_y;
                        mx_reg  <= mode_x;
                        my_reg  <= mode_y;
                        s_reg   <= s;
                        acc_reg <= '0;
                        idx_reg <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + prod;
                    idx_reg <= last_term ? '0 : idx_reg + IDXW'(1);
                end
                SCALE: begin
                    acc_reg <= prod;
                end
                default: begin
                end
            endcase
        end
    end

    assign g = acc_reg;

endmodule
